// File: rtl/serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_seq
// Purpose  : Bit-serial adder sequencer driving an external 3-to-8 decoder
//            full-adder stage; result is assembled LSB-first.
// Options  : SERIAL_ADDER_OVF_EN adds the two's-complement overflow port ovf.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic [2:0]       dec_a,
    output logic             dec_e1,
    output logic             dec_e2_low,
    output logic             dec_e3_low,
    input  logic             si,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_shift;

    assign w_shift = (r_state == S_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == c_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // cout tracks ci only while shifting so it is not disturbed when cin is latched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_sum   <= {si, r_sum[WIDTH-1:1]};
                    r_carry <= ci;
                    r_cout  <= ci;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // carry into the MSB is the carry presented during the final SHIFT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_shift && (r_cnt == c_last)) begin
            r_ovf <= r_carry ^ ci;
        end
    end

    assign ovf = r_ovf;
`endif

    assign dec_a      = w_shift ? {r_a[0], r_b[0], r_carry} : 3'b000;
    assign dec_e1     = w_shift;
    assign dec_e2_low = ~w_shift;
    assign dec_e3_low = ~w_shift;
    assign busy       = w_shift;
    assign done       = (r_state == S_DONE);
    assign sum        = r_sum;
    assign cout       = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_seq
// Purpose  : Self-checking bench for serial_adder_seq with a behavioural
//            decoder full-adder and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic [2:0]       dec_a;
    logic             dec_e1;
    logic             dec_e2_low;
    logic             dec_e3_low;
    logic             si;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Decoder full-adder stage: outputs only meaningful when fully enabled
    logic w_en;
    assign w_en = dec_e1 & ~dec_e2_low & ~dec_e3_low;
    assign si   = w_en & (dec_a[2] ^ dec_a[1] ^ dec_a[0]);
    assign ci   = w_en & ((dec_a[2] & dec_a[1]) | (dec_a[2] & dec_a[0]) | (dec_a[1] & dec_a[0]));

    serial_adder_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .cin        (cin),
        .dec_a      (dec_a),
        .dec_e1     (dec_e1),
        .dec_e2_low (dec_e2_low),
        .dec_e3_low (dec_e3_low),
        .si         (si),
        .ci         (ci),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .cout       (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_disabled(input string tag);
        check({tag, ".dec_a"}, 32'(dec_a), 32'd0);
        check({tag, ".e1"}, 32'(dec_e1), 32'd0);
        check({tag, ".e2"}, 32'(dec_e2_low), 32'd1);
        check({tag, ".e3"}, 32'(dec_e3_low), 32'd1);
    endtask

    // Carry into bit k of a+b+c, from plain integer arithmetic
    function automatic logic carry_into(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                        input logic c, input int k);
        int unsigned mask;
        int unsigned s;
        mask = (32'd1 << k) - 32'd1;
        s    = (int'(a) & mask) + (int'(b) & mask) + int'(c);
        return s[k];
    endfunction

    task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic c, input bit intrude);
        int unsigned full;
        full = int'(a) + int'(b) + int'(c);
        @(negedge clk);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        check("c0.busy", 32'(busy), 32'd0);
        check_disabled("c0");
        @(negedge clk);
        start = 1'b0;
        op_a  = WIDTH'($urandom);
        op_b  = WIDTH'($urandom);
        cin   = 1'($urandom);
        for (int k = 0; k < WIDTH; k++) begin
            if (intrude && k == 3) start = 1'b1;
            if (intrude && k == 4) start = 1'b0;
            check("shift.busy", 32'(busy), 32'd1);
            check("shift.done", 32'(done), 32'd0);
            check("shift.dec_a", 32'(dec_a), 32'({a[k], b[k], carry_into(a, b, c, k)}));
            check("shift.e1", 32'(dec_e1), 32'd1);
            check("shift.e2", 32'(dec_e2_low), 32'd0);
            check("shift.e3", 32'(dec_e3_low), 32'd0);
            @(negedge clk);
        end
        if (intrude) start = 1'b1;
        check("fin.done", 32'(done), 32'd1);
        check("fin.busy", 32'(busy), 32'd0);
        check("fin.sum", 32'(sum), full & ((32'd1 << WIDTH) - 32'd1));
        check("fin.cout", 32'(cout), 32'(full[WIDTH]));
`ifdef SERIAL_ADDER_OVF_EN
        check("fin.ovf", 32'(ovf), 32'(carry_into(a, b, c, WIDTH - 1) ^ full[WIDTH]));
`endif
        check_disabled("fin");
        @(negedge clk);
        start = 1'b0;
        check("post.done", 32'(done), 32'd0);
        check("post.busy", 32'(busy), 32'd0);
        check("post.sum", 32'(sum), full & ((32'd1 << WIDTH) - 32'd1));
        check("post.cout", 32'(cout), 32'(full[WIDTH]));
        check_disabled("post");
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".sum"}, 32'(sum), 32'd0);
        check({tag, ".cout"}, 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'd0);
`endif
        check_disabled(tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        run_add(8'h35, 8'h1A, 1'b0, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, 1'b0);
        run_add(8'h00, 8'h00, 1'b1, 1'b0);
        run_add(8'h10, 8'h20, 1'b0, 1'b1);
        run_add(8'h7F, 8'h01, 1'b0, 1'b0);
        run_add(8'hFF, 8'hFF, 1'b1, 1'b0);

        // Reset mid-operation
        @(negedge clk);
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("abort.no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        run_add(8'h01, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
